// File: rtl/ucaspian_pkg.sv
// Shared types and constants for the uCaspian time-step controller.
package ucaspian_pkg;

    localparam int unsigned STEP_W_DEF = 16;

    localparam logic CLR_ACT = 1'b0;
    localparam logic CLR_CFG = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_STEP       = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_CLEAR      = 3'd4,
        ST_CLEAR_WAIT = 3'd5
    } step_state_e;

endpackage

// File: rtl/ucaspian_sticky_mask.sv
// N-bit OR-accumulate register with synchronous clear; all_ones_c also folds in
// the current input so a final acknowledge is seen in the cycle it arrives.
module ucaspian_sticky_mask #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [N-1:0] set,
    output logic         all_ones_c
);

    logic [N-1:0] mask;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            mask <= '0;
        end else begin
            mask <= mask | set;
        end
    end

    assign all_ones_c = &(mask | set);

endmodule

// File: rtl/ucaspian_step_ctrl.sv
// Time-step sequencer: issues next_step to all units, waits for every step_done,
// runs host batches of steps and sequences activity/configuration clears.
module ucaspian_step_ctrl
    import ucaspian_pkg::*;
#(
    parameter int unsigned N_UNITS    = 3,
    parameter int unsigned STEP_W     = STEP_W_DEF,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned WDOG_W     = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run_vld,
    input  logic [STEP_W-1:0]  run_steps,
    output logic               run_rdy,
    output logic               run_done,
    input  logic               halt,
    input  logic               clr_vld,
    input  logic               clr_cfg,
    output logic               clr_rdy,
    output logic               clr_done,
    output logic               next_step,
    input  logic [N_UNITS-1:0] unit_step_done,
    output logic               clear_act,
    output logic               clear_config,
    input  logic [N_UNITS-1:0] unit_clear_done,
    output logic [STEP_W-1:0]  step_count,
    output logic [STEP_W-1:0]  steps_left,
    output logic               busy,
    output logic               wdog_err
);

    localparam int unsigned        SET_W     = 4;
    localparam logic [WDOG_W-1:0]  WDOG_LAST = {WDOG_W{1'b1}} - WDOG_W'(1);

    step_state_e          state, state_nxt;
    logic [SET_W-1:0]     settle_cnt, settle_nxt;
    logic [WDOG_W-1:0]    wdog_cnt, wdog_nxt;
    logic                 halt_flag, halt_nxt;
    logic                 clr_type, clr_type_nxt;
    logic [STEP_W-1:0]    step_count_nxt, steps_left_nxt;
    logic                 next_step_nxt, clear_act_nxt, clear_config_nxt;
    logic                 run_done_nxt, clr_done_nxt, wdog_err_nxt;
    logic                 mask_clear_c;
    logic [N_UNITS-1:0]   mask_set_c;
    logic                 mask_full_c;
    logic                 wdog_expire_c;

    ucaspian_sticky_mask #(.N(N_UNITS)) u_done_mask (
        .clk        (clk),
        .reset      (reset),
        .clear      (mask_clear_c),
        .set        (mask_set_c),
        .all_ones_c (mask_full_c)
    );

    assign run_rdy = (state == ST_IDLE) && !reset;
    assign clr_rdy = (state == ST_IDLE) && !reset;
    assign busy    = (state != ST_IDLE);

    // Watchdog fires as the counter would reach all-ones.
    assign wdog_expire_c = (wdog_cnt == WDOG_LAST);

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt      = state;
        settle_nxt     = settle_cnt;
        halt_nxt       = halt_flag;
        clr_type_nxt   = clr_type;
        step_count_nxt = step_count;
        steps_left_nxt = steps_left;
        run_done_nxt   = 1'b0;
        clr_done_nxt   = 1'b0;
        wdog_err_nxt   = wdog_err;
        mask_clear_c   = 1'b0;
        mask_set_c     = '0;

        case (state)
            ST_IDLE: begin
                if (clr_vld) begin
                    clr_type_nxt = clr_cfg;
                    state_nxt    = ST_CLEAR;
                end else if (run_vld) begin
                    if (run_steps == '0) begin
                        run_done_nxt = 1'b1;
                    end else begin
                        steps_left_nxt = run_steps;
                        state_nxt      = ST_STEP;
                    end
                end
            end
            ST_STEP: begin
                if (halt) halt_nxt = 1'b1;
                steps_left_nxt = steps_left - STEP_W'(1);
                step_count_nxt = step_count + STEP_W'(1);
                settle_nxt     = SET_W'(SETTLE_CYC);
                state_nxt      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (halt) halt_nxt = 1'b1;
                settle_nxt = settle_cnt - SET_W'(1);
                if (settle_cnt <= SET_W'(1)) state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (halt) halt_nxt = 1'b1;
                if (&unit_step_done) begin
                    if ((steps_left == '0) || halt_flag) begin
                        run_done_nxt = 1'b1;
                        halt_nxt     = 1'b0;
                        state_nxt    = ST_IDLE;
                    end else begin
                        state_nxt = ST_STEP;
                    end
                end else if (wdog_expire_c) begin
                    wdog_err_nxt = 1'b1;
                    halt_nxt     = 1'b0;
                    state_nxt    = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                mask_clear_c = 1'b1;
                state_nxt    = ST_CLEAR_WAIT;
            end
            ST_CLEAR_WAIT: begin
                mask_set_c = unit_clear_done;
                if (mask_full_c) begin
                    step_count_nxt = '0;
                    steps_left_nxt = '0;
                    clr_done_nxt   = 1'b1;
                    state_nxt      = ST_IDLE;
                end else if (wdog_expire_c) begin
                    wdog_err_nxt = 1'b1;
                    state_nxt    = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (state_nxt != state) begin
            wdog_nxt = '0;
        end else if ((state == ST_WAIT_DONE) || (state == ST_CLEAR_WAIT)) begin
            wdog_nxt = wdog_cnt + WDOG_W'(1);
        end else begin
            wdog_nxt = '0;
        end

        // Clear levels and next_step derive from the next state, so they never overlap.
        next_step_nxt    = (state_nxt == ST_STEP);
        clear_act_nxt    = ((state_nxt == ST_CLEAR) || (state_nxt == ST_CLEAR_WAIT))
                           && (clr_type_nxt == CLR_ACT);
        clear_config_nxt = ((state_nxt == ST_CLEAR) || (state_nxt == ST_CLEAR_WAIT))
                           && (clr_type_nxt == CLR_CFG);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            settle_cnt   <= '0;
            wdog_cnt     <= '0;
            halt_flag    <= 1'b0;
            clr_type     <= CLR_ACT;
            step_count   <= '0;
            steps_left   <= '0;
            next_step    <= 1'b0;
            clear_act    <= 1'b0;
            clear_config <= 1'b0;
            run_done     <= 1'b0;
            clr_done     <= 1'b0;
            wdog_err     <= 1'b0;
        end else begin
            state        <= state_nxt;
            settle_cnt   <= settle_nxt;
            wdog_cnt     <= wdog_nxt;
            halt_flag    <= halt_nxt;
            clr_type     <= clr_type_nxt;
            step_count   <= step_count_nxt;
            steps_left   <= steps_left_nxt;
            next_step    <= next_step_nxt;
            clear_act    <= clear_act_nxt;
            clear_config <= clear_config_nxt;
            run_done     <= run_done_nxt;
            clr_done     <= clr_done_nxt;
            wdog_err     <= wdog_err_nxt;
        end
    end

endmodule

// File: tb/tb_ucaspian_step_ctrl.sv
// Randomized bench for ucaspian_step_ctrl; expected timing comes from a cycle-offset
// model of the step/clear protocol.
module tb_ucaspian_step_ctrl;

    localparam int unsigned NU     = 3;
    localparam int unsigned SW     = 16;
    localparam int          SETTLE = 2;
    localparam int          MAXS   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          run_vld, run_rdy, run_done, halt;
    logic [SW-1:0] run_steps, step_count, steps_left;
    logic          clr_vld, clr_cfg, clr_rdy, clr_done, next_step;
    logic [NU-1:0] unit_step_done, unit_clear_done;
    logic          clear_act, clear_config, busy, wdog_err;

    logic          w_run_vld, w_run_rdy, w_run_done, w_halt;
    logic [SW-1:0] w_run_steps, w_step_count, w_steps_left;
    logic          w_clr_vld, w_clr_cfg, w_clr_rdy, w_clr_done, w_next_step;
    logic [NU-1:0] w_unit_step_done, w_unit_clear_done;
    logic          w_clear_act, w_clear_config, w_busy, w_wdog_err;

    int vectors, miscompares, cyc, model_sc, model_sl;

    ucaspian_step_ctrl #(.N_UNITS(NU), .STEP_W(SW), .SETTLE_CYC(SETTLE), .WDOG_W(20)) dut (
        .clk(clk), .reset(reset), .run_vld(run_vld), .run_steps(run_steps), .run_rdy(run_rdy),
        .run_done(run_done), .halt(halt), .clr_vld(clr_vld), .clr_cfg(clr_cfg), .clr_rdy(clr_rdy),
        .clr_done(clr_done), .next_step(next_step), .unit_step_done(unit_step_done),
        .clear_act(clear_act), .clear_config(clear_config), .unit_clear_done(unit_clear_done),
        .step_count(step_count), .steps_left(steps_left), .busy(busy), .wdog_err(wdog_err)
    );

    // Short watchdog instance so a stuck step can be observed quickly.
    ucaspian_step_ctrl #(.N_UNITS(NU), .STEP_W(SW), .SETTLE_CYC(SETTLE), .WDOG_W(8)) dut_wd (
        .clk(clk), .reset(reset), .run_vld(w_run_vld), .run_steps(w_run_steps), .run_rdy(w_run_rdy),
        .run_done(w_run_done), .halt(w_halt), .clr_vld(w_clr_vld), .clr_cfg(w_clr_cfg),
        .clr_rdy(w_clr_rdy), .clr_done(w_clr_done), .next_step(w_next_step),
        .unit_step_done(w_unit_step_done), .clear_act(w_clear_act), .clear_config(w_clear_config),
        .unit_clear_done(w_unit_clear_done), .step_count(w_step_count), .steps_left(w_steps_left),
        .busy(w_busy), .wdog_err(w_wdog_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Run n steps; each unit holds step_done low for d cycles after next_step.
    task automatic do_run(input int n, input int dlim, input int u1_hold, input int halt_step);
        int d[MAXS][NU];
        int per[MAXS];
        int exp_ns[$];
        int got_ns[$];
        int exp_steps, texp, t0, rd_time, cur, age, budget, extra, stray;
        exp_steps = n;
        if (halt_step > 0 && halt_step < n) exp_steps = halt_step;
        for (int k = 0; k < MAXS; k++) begin
            per[k] = SETTLE + 2;
            for (int u = 0; u < NU; u++) begin
                if (u1_hold >= 0) d[k][u] = (u == 1) ? u1_hold : 0;
                else              d[k][u] = int'($urandom_range(0, dlim));
                if (d[k][u] + 2 > per[k]) per[k] = d[k][u] + 2;
            end
        end
        texp = 1;
        for (int k = 0; k < exp_steps; k++) begin
            exp_ns.push_back(texp);
            texp += per[k];
        end

        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("run_rdy idle", run_rdy, 1);
        run_vld = 1'b1;
        run_steps = SW'(n);
        t0 = cyc;
        tick();
        run_vld = 1'b0;
        cur = -1; age = 0; rd_time = -1; budget = 0; stray = 0;
        while (rd_time < 0 && budget < 2000) begin
            if (next_step) begin
                got_ns.push_back(cyc - t0);
                cur++;
                age = 0;
            end else begin
                age++;
            end
            if (clear_act || clear_config) stray++;
            if (run_done) rd_time = cyc - t0;
            for (int u = 0; u < NU; u++)
                unit_step_done[u] = (cur < 0 || cur >= MAXS) ? 1'b1 : (age > d[cur][u]);
            halt = (halt_step > 0 && cur + 1 == halt_step && age == 1);
            tick();
            budget++;
        end
        halt = 1'b0;
        unit_step_done = '1;
        if (rd_time < 0) check("run_done timeout", 0, 1);
        check("next_step count", got_ns.size(), exp_steps);
        for (int k = 0; k < exp_steps && k < got_ns.size(); k++)
            check($sformatf("next_step[%0d] cycle", k), got_ns[k], exp_ns[k]);
        check("run_done cycle", rd_time, texp);
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            if (next_step || run_done) extra++;
            tick();
        end
        check("extra pulses after run", extra, 0);
        check("clear during run", stray, 0);
        model_sc = (model_sc + exp_steps) & 32'hFFFF;
        if (n != 0) model_sl = n - exp_steps;
        check("step_count", step_count, model_sc);
        check("steps_left", steps_left, model_sl);
        check("busy after run", busy, 0);
        check("run_rdy after run", run_rdy, 1);
    endtask

    // Clear with each unit pulsing clear_done p cycles after the level rises.
    task automatic do_clear(input bit cfg, input int p0, input int p1, input int p2, input bit with_run);
        int p[NU];
        int pm, t0, age, budget, cd_time, hi_cnt, wrong, ns_seen, rd_seen, extra;
        p[0] = p0; p[1] = p1; p[2] = p2;
        pm = 0;
        for (int u = 0; u < NU; u++) if (p[u] > pm) pm = p[u];
        check("clr_rdy idle", clr_rdy, 1);
        clr_vld = 1'b1;
        clr_cfg = cfg;
        if (with_run) begin
            run_vld = 1'b1;
            run_steps = SW'(7);
        end
        t0 = cyc;
        tick();
        clr_vld = 1'b0;
        clr_cfg = 1'b0;
        run_vld = 1'b0;
        check("run_rdy drops on clear", run_rdy, 0);
        age = 0; budget = 0; cd_time = -1; hi_cnt = 0; wrong = 0; ns_seen = 0; rd_seen = 0;
        while (cd_time < 0 && budget < pm + 50) begin
            if (cfg ? clear_config : clear_act) hi_cnt++;
            if (cfg ? clear_act : clear_config) wrong++;
            if (next_step) ns_seen++;
            if (run_done) rd_seen++;
            if (clr_done) cd_time = cyc - t0;
            for (int u = 0; u < NU; u++) unit_clear_done[u] = (age == p[u]);
            tick();
            age++;
            budget++;
        end
        unit_clear_done = '0;
        if (cd_time < 0) check("clr_done timeout", 0, 1);
        check("clear level cycles", hi_cnt, pm + 1);
        check("clr_done cycle", cd_time, pm + 2);
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            if (clr_done || clear_act || clear_config || next_step || run_done) extra++;
            tick();
        end
        check("activity after clear", extra, 0);
        check("other clear level", wrong, 0);
        check("next_step during clear", ns_seen, 0);
        check("run_done during clear", rd_seen, 0);
        model_sc = 0;
        model_sl = 0;
        check("step_count after clear", step_count, 0);
        check("steps_left after clear", steps_left, 0);
        check("run_rdy after clear", run_rdy, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL global time limit");
        $fatal(1, "time limit");
    end

    initial begin
        int n, hs, t0, ns_first, nsc, err_t, busy_at, rd, cd;
        vectors = 0; miscompares = 0; cyc = 0; model_sc = 0; model_sl = 0;
        reset = 1'b1;
        run_vld = 1'b0; run_steps = '0; halt = 1'b0; clr_vld = 1'b0; clr_cfg = 1'b0;
        unit_step_done = '1; unit_clear_done = '0;
        w_run_vld = 1'b0; w_run_steps = '0; w_halt = 1'b0; w_clr_vld = 1'b0; w_clr_cfg = 1'b0;
        w_unit_step_done = '0; w_unit_clear_done = '0;
        tick();
        tick();
        check("reset next_step", next_step, 0);
        check("reset clear_act", clear_act, 0);
        check("reset clear_config", clear_config, 0);
        check("reset run_done", run_done, 0);
        check("reset clr_done", clr_done, 0);
        check("reset wdog_err", wdog_err, 0);
        check("reset step_count", step_count, 0);
        check("reset steps_left", steps_left, 0);
        check("reset busy", busy, 0);
        check("run_rdy in reset", run_rdy, 0);
        reset = 1'b0;
        #1;
        check("run_rdy after reset", run_rdy, 1);
        check("clr_rdy after reset", clr_rdy, 1);

        do_run(3, 0, 0, 0);
        do_run(5, 0, 10, 0);
        do_clear(1'b0, 3, 40, 258, 1'b0);
        do_run(4, 0, 0, 0);
        do_clear(1'b1, 3, 40, 258, 1'b0);
        do_run(10, 0, 0, 4);
        do_clear(1'($urandom_range(0, 1)), int'($urandom_range(1, 20)),
                 int'($urandom_range(1, 20)), int'($urandom_range(1, 20)), 1'b1);
        do_run(0, 0, 0, 0);

        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 3) != 0) begin
                n = int'($urandom_range(0, 6));
                hs = 0;
                if (n > 0 && $urandom_range(0, 2) == 0) hs = int'($urandom_range(1, n));
                do_run(n, int'($urandom_range(0, 9)), -1, hs);
            end else begin
                do_clear(1'($urandom_range(0, 1)), int'($urandom_range(1, 30)),
                         int'($urandom_range(1, 30)), int'($urandom_range(1, 30)),
                         1'($urandom_range(0, 1)));
            end
        end

        // Stuck step on the short-watchdog instance.
        w_run_vld = 1'b1;
        w_run_steps = SW'(3);
        t0 = cyc;
        tick();
        w_run_vld = 1'b0;
        ns_first = -1; nsc = 0; err_t = -1; busy_at = -1; rd = 0;
        for (int i = 0; i < 600 && err_t < 0; i++) begin
            if (w_next_step) begin
                nsc++;
                if (ns_first < 0) ns_first = cyc - t0;
            end
            if (w_run_done) rd++;
            if (w_wdog_err) begin
                err_t = cyc - t0;
                busy_at = int'(w_busy);
            end
            tick();
        end
        check("wdog first next_step", ns_first, 1);
        check("wdog next_step count", nsc, 1);
        check("wdog_err cycle", err_t, 1 + (SETTLE + 1) + 255);
        check("wdog busy at error", busy_at, 0);
        check("wdog no run_done", rd, 0);
        check("wdog steps_left", w_steps_left, 2);
        repeat (3) tick();
        check("wdog_err sticky", w_wdog_err, 1);
        check("wdog run_rdy", w_run_rdy, 1);

        // Reset in the middle of a clear that never completes.
        do_run(2, 3, -1, 0);
        clr_vld = 1'b1;
        clr_cfg = 1'b0;
        tick();
        clr_vld = 1'b0;
        repeat (20) tick();
        check("clear_act before reset", clear_act, 1);
        reset = 1'b1;
        tick();
        check("clear_act after reset", clear_act, 0);
        check("busy after reset", busy, 0);
        check("clr_done at reset", clr_done, 0);
        check("step_count after reset", step_count, 0);
        check("run_rdy during reset", run_rdy, 0);
        reset = 1'b0;
        #1;
        check("run_rdy after mid-clear reset", run_rdy, 1);
        cd = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (clr_done || clear_act) cd++;
        end
        check("no clr_done after reset", cd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
